// File: rtl/can_data_len_tracker.sv
// CAN data-length tracker: decodes the DLC into a byte count, picks the CRC
// and assembles data-field bits into bytes, flagging the end of the field.
// Ports:
//   clk, rst (sync, active-high)
//   dlc_valid, dlc_in[3:0], fd_in, rtr_in : frame header strobe
//   bit_valid, bit_in                     : destuffed data bits, MSB first
//   abort                                 : discard the current frame
//   data_len[6:0], crc_sel[1:0], len_err  : header results
//   byte_out[7:0], byte_valid, data_done  : data-field results
//   busy                                  : high while collecting bits
// Optional CAN_DATA_BUF_EN adds a MAX_LEN x 8 byte buffer with
//   rd_addr[5:0] in and rd_data[7:0] out (1-cycle read latency).

module can_data_len_tracker #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dlc_valid,
  input  logic [3:0] dlc_in,
  input  logic       fd_in,
  input  logic       rtr_in,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       abort,
`ifdef CAN_DATA_BUF_EN
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
`endif
  output logic [6:0] data_len,
  output logic [1:0] crc_sel,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       data_done,
  output logic       busy,
  output logic       len_err
);

  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    DONE
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [2:0] bit_cnt;
  logic [6:0] byte_cnt;
  logic [6:0] shreg;

  logic [6:0] raw_len;
  logic [6:0] dec_len;
  logic       dec_clip;
  logic [1:0] dec_crc;
  logic       take_bit;
  logic       last_bit;
  logic       byte_end;
  logic [7:0] full_byte;

  always_comb begin
    raw_len = 7'd0;
    if (fd_in) begin
      unique case (dlc_in)
        4'd9:    raw_len = 7'd12;
        4'd10:   raw_len = 7'd16;
        4'd11:   raw_len = 7'd20;
        4'd12:   raw_len = 7'd24;
        4'd13:   raw_len = 7'd32;
        4'd14:   raw_len = 7'd48;
        4'd15:   raw_len = 7'd64;
        default: raw_len = {3'b000, dlc_in};
      endcase
    end else if (!rtr_in) begin
      raw_len = (dlc_in > 4'd8) ? 7'd8
                                : {3'b000, dlc_in};
    end
    dec_clip = (raw_len > LEN_MAX);
    dec_len  = dec_clip ? LEN_MAX : raw_len;
    if (!fd_in)
      dec_crc = 2'd0;
    else if (dec_len <= 7'd16)
      dec_crc = 2'd1;
    else
      dec_crc = 2'd2;
  end

  // Bits only count while collecting a frame; the
  // header strobe and abort both pre-empt them.
  assign take_bit  = (state == DATA) && bit_valid
                   && !abort && !dlc_valid;
  assign last_bit  = (bit_cnt == 3'd7);
  assign byte_end  = ((byte_cnt + 7'd1) == data_len);
  assign full_byte = {shreg, bit_in};

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = IDLE;
    end else if (dlc_valid) begin
      state_n = (dec_len != 7'd0) ? DATA : DONE;
    end else begin
      unique case (state)
        IDLE: state_n = IDLE;
        DATA: begin
          if (bit_valid && last_bit && byte_end)
            state_n = DONE;
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_len   <= 7'd0;
      crc_sel    <= 2'd0;
      len_err    <= 1'b0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
      data_done  <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 7'd0;
      shreg      <= 7'd0;
    end else begin
      byte_valid <= 1'b0;
      data_done  <= 1'b0;
      busy       <= (state_n == DATA);
      if (abort) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= 7'd0;
        shreg    <= 7'd0;
      end else if (dlc_valid) begin
        data_len  <= dec_len;
        crc_sel   <= dec_crc;
        len_err   <= dec_clip;
        bit_cnt   <= 3'd0;
        byte_cnt  <= 7'd0;
        shreg     <= 7'd0;
        // Empty field: done pulses straight from DONE.
        data_done <= (dec_len == 7'd0);
      end else if (take_bit) begin
        shreg   <= full_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (last_bit) begin
          byte_out   <= full_byte;
          byte_valid <= 1'b1;
          byte_cnt   <= byte_cnt + 7'd1;
          if (byte_end)
            data_done <= 1'b1;
        end
      end
    end
  end

`ifdef CAN_DATA_BUF_EN
  localparam int AW = $clog2(MAX_LEN);

  logic [7:0] mem [MAX_LEN];

  // Contents are never cleared; a new frame simply
  // overwrites them byte by byte.
  always_ff @(posedge clk) begin
    if (!rst && take_bit && last_bit)
      mem[byte_cnt[AW-1:0]] <= full_byte;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= 8'd0;
    else
      rd_data <= mem[rd_addr[AW-1:0]];
  end
`endif

endmodule

// File: tb/tb_can_data_len_tracker.sv
// Self-checking bench for can_data_len_tracker: table vectors,
// directed corner sequences and random traffic against a frame model.

module tb_can_data_len_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dlc_valid = 1'b0;
  logic [3:0] dlc_in = 4'd0;
  logic       fd_in = 1'b0;
  logic       rtr_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       abort = 1'b0;

  logic [6:0] a_len, b_len;
  logic [1:0] a_crc, b_crc;
  logic [7:0] a_byte, b_byte;
  logic       a_bv, a_dd, a_busy, a_err;
  logic       b_bv, b_dd, b_busy, b_err;
`ifdef CAN_DATA_BUF_EN
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] a_rd, b_rd;
`endif

  always #5 clk = ~clk;

  can_data_len_tracker #(.MAX_LEN(64)) dut_a (
    .clk(clk), .rst(rst),
    .dlc_valid(dlc_valid), .dlc_in(dlc_in),
    .fd_in(fd_in), .rtr_in(rtr_in),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .abort(abort),
`ifdef CAN_DATA_BUF_EN
    .rd_addr(rd_addr), .rd_data(a_rd),
`endif
    .data_len(a_len), .crc_sel(a_crc),
    .byte_out(a_byte), .byte_valid(a_bv),
    .data_done(a_dd), .busy(a_busy),
    .len_err(a_err)
  );

  can_data_len_tracker #(.MAX_LEN(8)) dut_b (
    .clk(clk), .rst(rst),
    .dlc_valid(dlc_valid), .dlc_in(dlc_in),
    .fd_in(fd_in), .rtr_in(rtr_in),
    .bit_valid(bit_valid), .bit_in(bit_in),
    .abort(abort),
`ifdef CAN_DATA_BUF_EN
    .rd_addr(rd_addr), .rd_data(b_rd),
`endif
    .data_len(b_len), .crc_sel(b_crc),
    .byte_out(b_byte), .byte_valid(b_bv),
    .data_done(b_dd), .busy(b_busy),
    .len_err(b_err)
  );

  int errs = 0;
  int checks = 0;
  int n_bv = 0;
  int n_dd = 0;
  logic [7:0] bq[$];

  int fd_tab[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8,
                     12, 16, 20, 24, 32, 48, 64};

  // Frame model state
  int m_active = 0;
  int m_len = 0;
  int m_crc = 0;
  int m_err = 0;
  int m_bits = 0;
  int m_acc = 0;
  int e_byte = 0;
  int e_bv = 0;
  int e_dd = 0;

  task automatic chk(string name, logic [31:0] act,
                     int exp);
    logic [31:0] e;
    e = exp;
    checks++;
    if (act !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, e);
    end
  endtask

  function automatic int dec(int code, bit fd, bit rtr,
                             int maxl, output bit clip);
    int l;
    if (fd)
      l = fd_tab[code];
    else if (rtr)
      l = 0;
    else
      l = (code > 8) ? 8 : code;
    clip = (l > maxl);
    return clip ? maxl : l;
  endfunction

  task automatic model_step();
    bit c;
    e_bv = 0;
    e_dd = 0;
    if (rst) begin
      m_active = 0; m_len = 0; m_crc = 0; m_err = 0;
      m_bits = 0; m_acc = 0; e_byte = 0;
    end else if (abort) begin
      m_active = 0; m_bits = 0; m_acc = 0;
    end else if (dlc_valid) begin
      m_len = dec(int'(dlc_in), fd_in, rtr_in, 64, c);
      m_err = int'(c);
      m_crc = !fd_in ? 0 : (m_len <= 16 ? 1 : 2);
      m_bits = 0;
      m_acc = 0;
      m_active = (m_len > 0) ? 1 : 0;
      e_dd = (m_len == 0) ? 1 : 0;
    end else if (bit_valid && m_active != 0) begin
      m_acc = (m_acc * 2 + int'(bit_in)) % 256;
      m_bits++;
      if (m_bits % 8 == 0) begin
        e_byte = m_acc;
        e_bv = 1;
        if (m_bits / 8 == m_len) begin
          e_dd = 1;
          m_active = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("len", 32'(a_len), m_len);
    chk("crc", 32'(a_crc), m_crc);
    chk("len_err", 32'(a_err), m_err);
    chk("byte_out", 32'(a_byte), e_byte);
    chk("byte_valid", 32'(a_bv), e_bv);
    chk("data_done", 32'(a_dd), e_dd);
    chk("busy", 32'(a_busy), m_active);
    if (a_bv === 1'b1) begin
      n_bv++;
      bq.push_back(a_byte);
    end
    if (a_dd === 1'b1)
      n_dd++;
  endtask

  task automatic send_dlc(logic [3:0] d, logic fd,
                          logic rtr);
    dlc_valid = 1'b1;
    dlc_in = d;
    fd_in = fd;
    rtr_in = rtr;
    tick();
    dlc_valid = 1'b0;
  endtask

  task automatic send_bits(logic [31:0] v, int n);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in = v[n-1-i];
      tick();
    end
    bit_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0] dlc;
    logic       fd;
    logic       rtr;
    int         len;
    int         crc;
  } vec_t;

  vec_t tv[10];

  initial begin
    tv[0] = '{4'd4,  1'b0, 1'b0, 4,  0};
    tv[1] = '{4'd15, 1'b0, 1'b0, 8,  0};
    tv[2] = '{4'd11, 1'b1, 1'b0, 20, 2};
    tv[3] = '{4'd10, 1'b1, 1'b0, 16, 1};
    tv[4] = '{4'd15, 1'b1, 1'b0, 64, 2};
    tv[5] = '{4'd5,  1'b0, 1'b1, 0,  0};
    tv[6] = '{4'd3,  1'b1, 1'b1, 3,  1};
    tv[7] = '{4'd9,  1'b0, 1'b0, 8,  0};
    tv[8] = '{4'd8,  1'b1, 1'b0, 8,  1};
    tv[9] = '{4'd9,  1'b1, 1'b0, 12, 1};

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_b_len", 32'(b_len), 0);
    chk("rst_b_err", 32'(b_err), 0);

    // Header decode table, both MAX_LEN builds
    foreach (tv[i]) begin
      send_dlc(tv[i].dlc, tv[i].fd, tv[i].rtr);
      chk("tv_len", 32'(a_len), tv[i].len);
      chk("tv_crc", 32'(a_crc), tv[i].crc);
      chk("tv_err", 32'(a_err), 0);
      chk("tvB_len", 32'(b_len),
          tv[i].len > 8 ? 8 : tv[i].len);
      chk("tvB_err", 32'(b_err),
          tv[i].len > 8 ? 1 : 0);
      if (tv[i].len == 0)
        chk("tv_zero_done", 32'(a_dd), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
    end

    // Classical 4-byte frame
    bq.delete();
    n_dd = 0;
    send_dlc(4'd4, 1'b0, 1'b0);
    send_bits(32'hDEADBEEF, 32);
    chk("dead_nbytes", 32'(bq.size()), 4);
    if (bq.size() == 4) begin
      chk("dead_b0", 32'(bq[0]), 32'hDE);
      chk("dead_b1", 32'(bq[1]), 32'hAD);
      chk("dead_b2", 32'(bq[2]), 32'hBE);
      chk("dead_b3", 32'(bq[3]), 32'hEF);
    end
    chk("dead_done", 32'(n_dd), 1);
`ifdef CAN_DATA_BUF_EN
    rd_addr = 6'd3;
    tick();
    chk("buf_rd3", 32'(a_rd), 32'hEF);
    rd_addr = 6'd0;
    tick();
    chk("buf_rd0", 32'(a_rd), 32'hDE);
`endif
    // Bits after completion are ignored
    n_bv = 0;
    send_bits(32'hFF, 8);
    chk("idle_bits", 32'(n_bv), 0);

    // FD 20-byte frame
    n_bv = 0;
    n_dd = 0;
    send_dlc(4'd11, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      send_bits($urandom, 32);
    chk("fd20_nbytes", 32'(n_bv), 20);
    chk("fd20_done", 32'(n_dd), 1);

    // Abort after 13 bits of an 8-byte frame
    n_bv = 0;
    n_dd = 0;
    send_dlc(4'd8, 1'b0, 1'b0);
    send_bits($urandom, 13);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_nbytes", 32'(n_bv), 1);
    chk("abort_done", 32'(n_dd), 0);
    chk("abort_busy", 32'(a_busy), 0);
    send_dlc(4'd1, 1'b0, 1'b0);
    send_bits(32'hA5, 8);
    chk("after_abort_done", 32'(n_dd), 1);
    chk("after_abort_byte", 32'(a_byte), 32'hA5);

    // Abort wins over coincident strobes
    abort = 1'b1;
    dlc_valid = 1'b1;
    dlc_in = 4'd2;
    bit_valid = 1'b1;
    tick();
    abort = 1'b0;
    dlc_valid = 1'b0;
    bit_valid = 1'b0;
    chk("abort_prio_busy", 32'(a_busy), 0);

    // Reset mid-frame
    send_dlc(4'd4, 1'b1, 1'b0);
    send_bits($urandom, 12);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_len", 32'(a_len), 0);
    chk("rst_mid_byte", 32'(a_byte), 0);
    chk("rst_mid_busy", 32'(a_busy), 0);
    n_dd = 0;
    send_bits($urandom, 24);
    chk("rst_mid_nodone", 32'(n_dd), 0);

    // Restart by a new header mid-frame
    n_dd = 0;
    n_bv = 0;
    send_dlc(4'd2, 1'b0, 1'b0);
    send_bits($urandom, 10);
    send_dlc(4'd1, 1'b0, 1'b0);
    send_bits(32'h3C, 8);
    chk("restart_done", 32'(n_dd), 1);
    chk("restart_nbytes", 32'(n_bv), 2);
    chk("restart_byte", 32'(a_byte), 32'h3C);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 500) == 0;
      abort = ($urandom % 150) == 0;
      dlc_valid = ($urandom % 120) == 0;
      dlc_in = 4'($urandom);
      fd_in = 1'($urandom);
      rtr_in = ($urandom % 4) == 0;
      bit_valid = ($urandom % 4) != 0;
      bit_in = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    abort = 1'b0;
    dlc_valid = 1'b0;
    bit_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/can_data_len_tracker.md
CAN_DATA_LEN_TRACKER -- requirements
Module: can_data_len_tracker

Interface
REQ-001 Parameter MAX_LEN, default 64, SHALL set the maximum data-field bytes accepted; legal values are 8 and 64.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 dlc_valid  input  1  one-cycle strobe: dlc_in, fd_in and rtr_in are valid.
REQ-005 dlc_in  input  4  raw DLC field.
REQ-006 fd_in  input  1  1 = FD frame (FD length table); 0 = classical frame.
REQ-007 rtr_in  input  1  1 = remote frame (no data field).
REQ-008 bit_valid  input  1  one-cycle strobe per destuffed sampled data-field bit.
REQ-009 bit_in  input  1  data bit, MSB of each byte first.
REQ-010 abort  input  1  error frame or bus-off: discard the current frame.
REQ-011 data_len  output  7  decoded byte count of the current frame.
REQ-012 crc_sel  output  2  0 = CRC15, 1 = CRC17, 2 = CRC21.
REQ-013 byte_out  output  8  last assembled byte.
REQ-014 byte_valid  output  1  one-cycle pulse: byte_out is new.
REQ-015 data_done  output  1  one-cycle pulse: the data field is complete.
REQ-016 busy  output  1  high while in DATA state.
REQ-017 len_err  output  1  sticky until the next dlc_valid: the decoded length was clipped to MAX_LEN.

Function
REQ-018 The FSM SHALL have states IDLE, DATA and DONE. DONE lasts exactly one cycle and then returns to IDLE.
REQ-019 Classical decode SHALL be: codes 0-8 map to 0-8 bytes; codes 9-15 map to 8.
REQ-020 FD decode SHALL be: codes 0-8 map to 0-8; 9..15 map to 12, 16, 20, 24, 32, 48, 64.
REQ-021 A frame with rtr_in=1 and fd_in=0 SHALL set data_len=0. rtr_in SHALL be ignored when fd_in=1.
REQ-022 If the decoded length exceeds MAX_LEN, data_len SHALL be set to MAX_LEN and len_err SHALL assert.
REQ-023 On dlc_valid, data_len, crc_sel and len_err SHALL be registered; they are valid on the next cycle.
REQ-024 crc_sel mapping SHALL be:
- fd_in=0 -> 0
- fd_in=1 and data_len<=16 -> 1
- fd_in=1 and data_len>16 -> 2
REQ-025 Transitions out of IDLE on dlc_valid SHALL be:
- data_len>0 -> DATA
- data_len=0 -> DONE, so data_done pulses exactly 1 cycle after dlc_valid.
REQ-026 In DATA, each bit_valid SHALL shift bit_in into the byte register and increment a 3-bit bit counter.
REQ-027 On the 8th bit, byte_out and byte_valid SHALL update one cycle after that bit_valid. The byte counter SHALL increment and the bit counter SHALL wrap to 0.
REQ-028 When the byte counter reaches data_len, data_done SHALL pulse in the same cycle as the final byte_valid. The FSM SHALL then return to IDLE.
REQ-029 bit_valid SHALL be ignored in IDLE and DONE, including when it is coincident with dlc_valid.
REQ-030 A dlc_valid received in DATA SHALL restart the frame: new length latched, counters cleared, no data_done for the old frame.
REQ-031 abort in any state SHALL return the FSM to IDLE next cycle with counters cleared; byte_valid and data_done SHALL not pulse. abort SHALL take priority over coincident dlc_valid and bit_valid.
REQ-032 Outputs SHALL be fully registered with no combinational input-to-output path.

Reset
REQ-033 With rst high, the block SHALL enter IDLE next cycle with these values:
- data_len=0, crc_sel=0, byte_out=0
- byte_valid=0, data_done=0, busy=0, len_err=0
- all counters cleared
REQ-034 rst SHALL take priority over abort, dlc_valid and bit_valid. A reset mid-frame SHALL discard the frame silently.

Configuration
REQ-035 Macro CAN_DATA_BUF_EN: when defined, a MAX_LEN x 8 buffer SHALL store each assembled byte at its byte index. The buffer adds these ports:
- rd_addr  input  6
- rd_data  output  8, registered with 1-cycle read latency
The buffer contents SHALL be retained after data_done until the next dlc_valid.
REQ-036 Without CAN_DATA_BUF_EN, the buffer and its ports SHALL be absent; bytes are available only via byte_out/byte_valid.

Verification
REQ-037 Classical, dlc 4'b0100, 32 bits 0xDEADBEEF -> data_len=4, crc_sel=0; bytes DE, AD, BE, EF; data_done with 4th byte_valid.
REQ-038 FD, dlc 4'b1011 -> data_len=20, crc_sel=2; FD, dlc 4'b1010 -> data_len=16, crc_sel=1; 20 byte_valid pulses, then data_done.
REQ-039 Classical, dlc 4'b1111 -> data_len=8; remote frame (rtr=1), dlc 5 -> data_len=0, data_done 1 cycle after dlc_valid.
REQ-040 MAX_LEN=8, FD, dlc 4'b1111 -> data_len=8, len_err=1; len_err clears on the next dlc_valid.
REQ-041 abort after 13 bits of an 8-byte frame -> exactly one byte_valid, no data_done, busy=0. A following 1-byte frame completes normally.
REQ-042 rst mid-frame, and dlc_valid restart mid-frame -> outputs at reset values and no stale data_done. With CAN_DATA_BUF_EN, rd_addr=3 returns the 4th byte one cycle later.
